// File: rtl/sysid_boot_checker.sv
`default_nettype none
// ============================================================================
// Module      : sysid_boot_checker
// Description : Avalon-MM read master that checks the system-ID slave.
//               After reset release (AUTO_START=1) or on a start pulse it
//               reads word 0 (system ID) and then word 1 (build timestamp).
//               It compares both words with the expected constants and
//               reports pass/fail. The result gates the downstream video
//               pipeline enable and drives a debug LED/readback.
//
// Ports       : clock, reset_n   system clock and async active-low reset
//               start            one-cycle check request (IDLE only)
//               m_address/m_read Avalon read command (0 = ID, 1 = TS)
//               m_readdata       read data from the slave
//               m_waitrequest    slave stall
//               busy             check in progress (any state but IDLE)
//               done             one-cycle pulse when a check completes
//               pass             last check matched both words
//               id_mismatch      ID word differed
//               ts_mismatch      timestamp word differed
//               timeout          a read stalled for TIMEOUT_CYCLES cycles
//               id_value         ID word as captured
//               ts_value         timestamp word as captured
// Revision    : 1.0 - initial release
// ============================================================================
module sysid_boot_checker #(
    parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TS    = 32'h5652_7889,
    parameter int          READ_LATENCY   = 0,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter bit          AUTO_START     = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        m_address,
    output logic        m_read,
    input  logic [31:0] m_readdata,
    input  logic        m_waitrequest,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        id_mismatch,
    output logic        ts_mismatch,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    // Stall count at which a read is abandoned, and the last latency cycle.
    localparam logic [15:0] c_WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]  c_LAT_LAST  = 3'(READ_LATENCY - 1);
    localparam bit          c_ZERO_LAT  = (READ_LATENCY == 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD_ID  = 3'd1,
        S_LAT_ID = 3'd2,
        S_RD_TS  = 3'd3,
        S_LAT_TS = 3'd4,
        S_CMP    = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    state_t      r_state;
    logic        r_auto_pending;
    logic [15:0] r_wait_cnt;
    logic [2:0]  r_lat_cnt;
    logic        r_read;
    logic        r_address;
    logic        r_busy;
    logic        r_done;
    logic        r_pass;
    logic        r_id_mm;
    logic        r_ts_mm;
    logic        r_timeout;
    logic [31:0] r_id_value;
    logic [31:0] r_ts_value;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= S_IDLE;
            r_auto_pending <= AUTO_START;
            r_wait_cnt     <= 16'd0;
            r_lat_cnt      <= 3'd0;
            r_read         <= 1'b0;
            r_address      <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_pass         <= 1'b0;
            r_id_mm        <= 1'b0;
            r_ts_mm        <= 1'b0;
            r_timeout      <= 1'b0;
            r_id_value     <= 32'd0;
            r_ts_value     <= 32'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // The auto-start request behaves exactly like one start pulse.
                    if (start || r_auto_pending) begin
                        r_auto_pending <= 1'b0;
                        r_pass         <= 1'b0;
                        r_id_mm        <= 1'b0;
                        r_ts_mm        <= 1'b0;
                        r_timeout      <= 1'b0;
                        r_read         <= 1'b1;
                        r_address      <= 1'b0;
                        r_wait_cnt     <= 16'd0;
                        r_busy         <= 1'b1;
                        r_state        <= S_RD_ID;
                    end
                end

                S_RD_ID: begin
                    if (!m_waitrequest) begin
                        if (c_ZERO_LAT) begin
                            // Data is valid in the accept cycle; chain straight
                            // into the timestamp read with m_read kept high.
                            r_id_value <= m_readdata;
                            r_address  <= 1'b1;
                            r_wait_cnt <= 16'd0;
                            r_state    <= S_RD_TS;
                        end else begin
                            r_read    <= 1'b0;
                            r_lat_cnt <= 3'd0;
                            r_state   <= S_LAT_ID;
                        end
                    end else if (r_wait_cnt == c_WAIT_LAST) begin
                        // Abandon the check; the timestamp is never requested.
                        r_read    <= 1'b0;
                        r_timeout <= 1'b1;
                        r_pass    <= 1'b0;
                        r_done    <= 1'b1;
                        r_state   <= S_DONE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 16'd1;
                    end
                end

                S_LAT_ID: begin
                    if (r_lat_cnt == c_LAT_LAST) begin
                        r_id_value <= m_readdata;
                        r_read     <= 1'b1;
                        r_address  <= 1'b1;
                        r_wait_cnt <= 16'd0;
                        r_state    <= S_RD_TS;
                    end else begin
                        r_lat_cnt <= r_lat_cnt + 3'd1;
                    end
                end

                S_RD_TS: begin
                    if (!m_waitrequest) begin
                        r_read <= 1'b0;
                        if (c_ZERO_LAT) begin
                            r_ts_value <= m_readdata;
                            r_state    <= S_CMP;
                        end else begin
                            r_lat_cnt <= 3'd0;
                            r_state   <= S_LAT_TS;
                        end
                    end else if (r_wait_cnt == c_WAIT_LAST) begin
                        r_read    <= 1'b0;
                        r_timeout <= 1'b1;
                        r_pass    <= 1'b0;
                        r_done    <= 1'b1;
                        r_state   <= S_DONE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 16'd1;
                    end
                end

                S_LAT_TS: begin
                    if (r_lat_cnt == c_LAT_LAST) begin
                        r_ts_value <= m_readdata;
                        r_state    <= S_CMP;
                    end else begin
                        r_lat_cnt <= r_lat_cnt + 3'd1;
                    end
                end

                S_CMP: begin
                    // Flags and pass are written together so they are all
                    // valid in the same cycle as the done pulse.
                    r_id_mm <= (r_id_value != EXPECTED_ID);
                    r_ts_mm <= (r_ts_value != EXPECTED_TS);
                    r_pass  <= (r_id_value == EXPECTED_ID) &&
                               (r_ts_value == EXPECTED_TS) && !r_timeout;
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end

                S_DONE: begin
                    // start is deliberately not looked at here.
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_read  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign m_address   = r_address;
    assign m_read      = r_read;
    assign busy        = r_busy;
    assign done        = r_done;
    assign pass        = r_pass;
    assign id_mismatch = r_id_mm;
    assign ts_mismatch = r_ts_mm;
    assign timeout     = r_timeout;
    assign id_value    = r_id_value;
    assign ts_value    = r_ts_value;

endmodule
`default_nettype wire

// File: tb/tb_sysid_boot_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_sysid_boot_checker
// Description : Bench for sysid_boot_checker. It uses two instances:
//               dut0 has zero latency, TIMEOUT 255 and auto start.
//               dut1 has READ_LATENCY 2, TIMEOUT 8 and no auto start.
//               Each instance has its own Avalon slave model. Expected
//               results and the done cycle come from the stall counts,
//               the latency and the data words.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sysid_boot_checker;

    localparam logic [31:0] c_EXP_ID = 32'h0000_0000;
    localparam logic [31:0] c_EXP_TS = 32'h5652_7889;

    logic        clk = 1'b0;
    logic        rst_n         [2];
    logic        start         [2];
    logic        m_address     [2];
    logic        m_read        [2];
    logic [31:0] m_readdata    [2];
    logic        m_waitrequest [2];
    logic        busy          [2];
    logic        done          [2];
    logic        pass          [2];
    logic        id_mismatch   [2];
    logic        ts_mismatch   [2];
    logic        timeout       [2];
    logic [31:0] id_value      [2];
    logic [31:0] ts_value      [2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sysid_boot_checker #(
        .EXPECTED_ID(c_EXP_ID), .EXPECTED_TS(c_EXP_TS),
        .READ_LATENCY(0), .TIMEOUT_CYCLES(255), .AUTO_START(1'b1)
    ) dut0 (
        .clock(clk), .reset_n(rst_n[0]), .start(start[0]),
        .m_address(m_address[0]), .m_read(m_read[0]),
        .m_readdata(m_readdata[0]), .m_waitrequest(m_waitrequest[0]),
        .busy(busy[0]), .done(done[0]), .pass(pass[0]),
        .id_mismatch(id_mismatch[0]), .ts_mismatch(ts_mismatch[0]),
        .timeout(timeout[0]), .id_value(id_value[0]), .ts_value(ts_value[0])
    );

    sysid_boot_checker #(
        .EXPECTED_ID(c_EXP_ID), .EXPECTED_TS(c_EXP_TS),
        .READ_LATENCY(2), .TIMEOUT_CYCLES(8), .AUTO_START(1'b0)
    ) dut1 (
        .clock(clk), .reset_n(rst_n[1]), .start(start[1]),
        .m_address(m_address[1]), .m_read(m_read[1]),
        .m_readdata(m_readdata[1]), .m_waitrequest(m_waitrequest[1]),
        .busy(busy[1]), .done(done[1]), .pass(pass[1]),
        .id_mismatch(id_mismatch[1]), .ts_mismatch(ts_mismatch[1]),
        .timeout(timeout[1]), .id_value(id_value[1]), .ts_value(ts_value[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- slave models (act on the falling edge) ---------------
    int          stall_cfg [2][2];   // waitrequest cycles before accept, per address
    logic [31:0] data_cfg  [2][2];
    int          lat_cfg   [2] = '{0, 2};
    int          s_cnt     [2];
    int          lat_left  [2];
    logic [31:0] lat_data  [2];
    bit          prev_acc  [2];
    logic        prev_addr [2];
    bit          prev_stall[2];
    int          addr0_cycles [2];
    int          addr1_cycles [2];

    for (genvar g = 0; g < 2; g++) begin : g_slave
        always @(negedge clk) begin
            if (!rst_n[g]) begin
                s_cnt[g]         = 0;
                lat_left[g]      = 0;
                prev_acc[g]      = 1'b0;
                prev_stall[g]    = 1'b0;
                m_waitrequest[g] = 1'b0;
                m_readdata[g]    = $urandom;
            end else begin
                if (lat_left[g] > 0) lat_left[g]--;
                if (prev_acc[g]) begin
                    lat_left[g] = lat_cfg[g];
                    lat_data[g] = data_cfg[g][prev_addr[g]];
                end
                if (prev_stall[g] && m_read[g])
                    check("addr_stable_in_stall", 32'(m_address[g]), 32'(prev_addr[g]));
                // Read data is valid only in its own cycle; noise otherwise.
                m_readdata[g] = $urandom;
                if (lat_cfg[g] == 0 && m_read[g])
                    m_readdata[g] = data_cfg[g][m_address[g]];
                else if (lat_left[g] == 1)
                    m_readdata[g] = lat_data[g];
                if (m_read[g]) begin
                    if (m_address[g]) addr1_cycles[g]++;
                    else              addr0_cycles[g]++;
                    if (s_cnt[g] < stall_cfg[g][m_address[g]]) begin
                        m_waitrequest[g] = 1'b1;
                        s_cnt[g]++;
                    end else begin
                        m_waitrequest[g] = 1'b0;
                        s_cnt[g] = 0;
                    end
                end else begin
                    s_cnt[g] = 0;
                    m_waitrequest[g] = 1'($urandom_range(0, 1));
                end
                prev_acc[g]   = m_read[g] && !m_waitrequest[g];
                prev_stall[g] = m_read[g] && m_waitrequest[g];
                prev_addr[g]  = m_address[g];
            end
        end
    end

    // ---------------- reference model state ---------------------------------
    logic [31:0] mdl_id [2] = '{32'd0, 32'd0};
    logic [31:0] mdl_ts [2] = '{32'd0, 32'd0};

    function automatic logic [31:0] pick(input logic [31:0] good);
        return ($urandom_range(0, 2) == 0) ? 32'($urandom) : good;
    endfunction

    // Runs one check. how=0: start pulse, how=1: reset release (auto start).
    // This task is called and returns one time unit after a rising edge.
    task automatic run_check(input int d, input int how, input int s_id, input int s_ts,
                             input logic [31:0] vid, input logic [31:0] vts,
                             input bit poke_busy, input bit poke_done);
        int L, T, kexp, k, rd_ts;
        bit to_id, to_ts, e_to, e_idm, e_tsm, e_pass;
        logic [31:0] e_id, e_ts;
        L = (d == 1) ? 2 : 0;
        T = (d == 1) ? 8 : 255;
        stall_cfg[d][0] = s_id;  stall_cfg[d][1] = s_ts;
        data_cfg[d][0]  = vid;   data_cfg[d][1]  = vts;
        addr0_cycles[d] = 0;     addr1_cycles[d] = 0;
        to_id = (s_id >= T);
        to_ts = 1'b0;
        e_id  = mdl_id[d];
        e_ts  = mdl_ts[d];
        // Cycle numbers count from the cycle in which start is high (cycle 0).
        if (to_id) begin
            kexp = 1 + T;
        end else begin
            e_id  = vid;
            rd_ts = (1 + s_id) + 1 + L;          // first cycle of the TS read
            if (s_ts >= T) begin
                to_ts = 1'b1;
                kexp  = rd_ts + T;
            end else begin
                e_ts = vts;
                kexp = rd_ts + s_ts + L + 2;     // data, compare, then done
            end
        end
        e_to   = to_id || to_ts;
        e_idm  = !e_to && (e_id != c_EXP_ID);
        e_tsm  = !e_to && (e_ts != c_EXP_TS);
        e_pass = !e_to && !e_idm && !e_tsm;

        if (how == 0) start[d] = 1'b1;
        else          rst_n[d] = 1'b1;
        k = 0;
        do begin
            @(posedge clk); #1;
            k++;
            if (k == 1) begin
                start[d] = 1'b0;
                check("busy_after_start", 32'(busy[d]), 32'd1);
            end
            if (poke_busy && k == 2) start[d] = 1'b1;
            if (poke_busy && k == 3) start[d] = 1'b0;
        end while (!done[d] && k < 400);

        check("done_cycle",  32'(k), 32'(kexp));
        check("pass",        32'(pass[d]), 32'(e_pass));
        check("id_mismatch", 32'(id_mismatch[d]), 32'(e_idm));
        check("ts_mismatch", 32'(ts_mismatch[d]), 32'(e_tsm));
        check("timeout",     32'(timeout[d]), 32'(e_to));
        check("id_value",    id_value[d], e_id);
        check("ts_value",    ts_value[d], e_ts);
        check("ts_read_issued", 32'(addr1_cycles[d] > 0), 32'(!to_id));
        if (to_id) check("id_read_cycles", 32'(addr0_cycles[d]), 32'(T));
        mdl_id[d] = e_id;
        mdl_ts[d] = e_ts;

        if (poke_done) start[d] = 1'b1;
        @(posedge clk); #1;
        start[d] = 1'b0;
        check("done_one_cycle", 32'(done[d]), 32'd0);
        check("idle_after_done", 32'(busy[d]), 32'd0);
        @(posedge clk); #1;
        check("still_idle", 32'(busy[d]), 32'd0);
        check("pass_sticky", 32'(pass[d]), 32'(e_pass));
    endtask

    task automatic check_all_zero(input int d, input string tag);
        check({tag, "_m_read"},  32'(m_read[d]), 32'd0);
        check({tag, "_m_addr"},  32'(m_address[d]), 32'd0);
        check({tag, "_busy"},    32'(busy[d]), 32'd0);
        check({tag, "_done"},    32'(done[d]), 32'd0);
        check({tag, "_flags"},   32'({pass[d], id_mismatch[d], ts_mismatch[d], timeout[d]}), 32'd0);
        check({tag, "_id_val"},  id_value[d], 32'd0);
        check({tag, "_ts_val"},  ts_value[d], 32'd0);
    endtask

    initial begin
        logic [31:0] v;
        int d;
        rst_n[0] = 1'b0; rst_n[1] = 1'b0;
        start[0] = 1'b0; start[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            stall_cfg[i][0] = 0; stall_cfg[i][1] = 0;
            data_cfg[i][0]  = c_EXP_ID; data_cfg[i][1] = c_EXP_TS;
            addr0_cycles[i] = 0; addr1_cycles[i] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        check_all_zero(0, "reset0");
        check_all_zero(1, "reset1");
        rst_n[1] = 1'b1;

        // Auto start after reset release with a zero-wait, matching slave.
        run_check(0, 1, 0, 0, c_EXP_ID, c_EXP_TS, 1'b0, 1'b0);
        check("no_autostart_dut1", 32'(busy[1]), 32'd0);
        // Wrong ID word.
        run_check(0, 0, 0, 0, 32'h0000_0001, c_EXP_TS, 1'b0, 1'b0);
        // Three stall cycles per read with READ_LATENCY=2.
        run_check(1, 0, 3, 3, c_EXP_ID, c_EXP_TS, 1'b0, 1'b0);
        // Wrong timestamp word, then stalls one short of the timeout.
        run_check(1, 0, 0, 0, c_EXP_ID, 32'h1234_5678, 1'b0, 1'b0);
        run_check(1, 0, 7, 7, c_EXP_ID, c_EXP_TS, 1'b0, 1'b1);
        // ID read stuck; a start during busy must be ignored.
        run_check(1, 0, 1000, 0, c_EXP_ID, c_EXP_TS, 1'b1, 1'b0);
        // Timestamp read stuck after a good ID read.
        run_check(1, 0, 0, 1000, 32'h0000_0002, c_EXP_TS, 1'b0, 1'b1);
        run_check(0, 0, 2, 1, c_EXP_ID, c_EXP_TS, 1'b1, 1'b1);

        // Reset asserted while the timestamp data is still in flight.
        stall_cfg[1][0] = 0; stall_cfg[1][1] = 0;
        data_cfg[1][0] = 32'hA5A5_0F0F; data_cfg[1][1] = c_EXP_TS;
        start[1] = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            if (k == 1) start[1] = 1'b0;
        end
        check("lat_ts_busy", 32'(busy[1]), 32'd1);
        check("lat_ts_id_captured", id_value[1], 32'hA5A5_0F0F);
        rst_n[1] = 1'b0;
        #1;
        check_all_zero(1, "midreset");
        @(posedge clk); #1;
        rst_n[1] = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("idle_after_reset", 32'(busy[1]), 32'd0);
        check("no_read_after_reset", 32'(m_read[1]), 32'd0);
        mdl_id[1] = 32'd0;
        mdl_ts[1] = 32'd0;

        // Randomised checks on both instances.
        for (int n = 0; n < 24; n++) begin
            d = int'($urandom_range(0, 1));
            v = pick(c_EXP_ID);
            run_check(d, 0,
                      int'($urandom_range(0, (d == 1) ? 9 : 4)),
                      int'($urandom_range(0, (d == 1) ? 9 : 4)),
                      v, pick(c_EXP_TS),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
